// File: rtl/push_debounce.sv
// push_debounce
// Turns two raw board push buttons into clean load strobes for the downstream
// 4-bit equality comparator. Each button is synchronised, debounced by its own
// stability counter and state machine, and arbitrated so push1 and push2 are
// never high in the same cycle.
//
// Build option: define PUSH_DEBOUNCE_PULSE_EN for one-cycle press strobes on
// push1/push2. Without it, push1/push2 follow the debounced levels, with
// button 1 taking priority over button 2.
module push_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn_raw,
  output logic       push1,
  output logic       push2,
  output logic [1:0] btn_level
);

  typedef enum logic [1:0] {
    IDLE,
    ARM_PRESS,
    HELD,
    ARM_RELEASE
  } state_t;

  // The counter stops here; reaching it on the incremented value completes
  // DEBOUNCE_CYCLES consecutive stable samples, counting the one that left the
  // stable state.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] s0;
  logic [1:0] s1;

`ifdef PUSH_DEBOUNCE_PULSE_EN
  logic [1:0] press_evt;
`endif

  // Two-flop synchroniser for both asynchronous button inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= 2'b00;
      s1 <= 2'b00;
    end else begin
      s0 <= btn_raw;
      s1 <= s0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_btn
      state_t           state;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_inc;
      logic             at_limit;
      logic             level;

      assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      assign at_limit = (cnt_inc == CNT_MAX);
      assign btn_level[g] = level;

`ifdef PUSH_DEBOUNCE_PULSE_EN
      assign press_evt[g] = (state == ARM_PRESS) && s1[g] && at_limit;
`endif

      // Debounce state machine: a level change is accepted only after the
      // synchronised input stays stable long enough; any bounce aborts it
      always_ff @(posedge clk) begin
        if (rst) begin
          state <= IDLE;
          cnt   <= '0;
          level <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              level <= 1'b0;
              if (s1[g]) begin
                cnt   <= '0;
                state <= ARM_PRESS;
              end
            end
            ARM_PRESS: begin
              if (!s1[g]) begin
                state <= IDLE;
              end else begin
                cnt <= cnt_inc;
                if (at_limit) begin
                  state <= HELD;
                  level <= 1'b1;
                end
              end
            end
            HELD: begin
              level <= 1'b1;
              if (!s1[g]) begin
                cnt   <= '0;
                state <= ARM_RELEASE;
              end
            end
            ARM_RELEASE: begin
              if (s1[g]) begin
                state <= HELD;
              end else begin
                cnt <= cnt_inc;
                if (at_limit) begin
                  state <= IDLE;
                  level <= 1'b0;
                end
              end
            end
            default: begin
              state <= IDLE;
              cnt   <= '0;
              level <= 1'b0;
            end
          endcase
        end
      end
    end
  endgenerate

`ifdef PUSH_DEBOUNCE_PULSE_EN
  logic pend2;

  // Strobe arbitration: button 1 wins a tie and button 2 is deferred one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      push1 <= 1'b0;
      push2 <= 1'b0;
      pend2 <= 1'b0;
    end else begin
      push1 <= press_evt[0];
      push2 <= pend2 | (press_evt[1] & ~press_evt[0]);
      pend2 <= press_evt[1] & press_evt[0];
    end
  end
`else
  // Level mode: outputs follow the debounced levels, button 1 masks button 2
  always_comb begin
    push1 = btn_level[0];
    push2 = btn_level[1] & ~btn_level[0];
  end
`endif

endmodule

// File: tb/tb_push_debounce.sv
// Directed testbench for push_debounce with DEBOUNCE_CYCLES = 4.
// Expected push values follow whichever build is compiled: one-cycle strobes
// when PUSH_DEBOUNCE_PULSE_EN is defined, debounced levels otherwise.
module tb_push_debounce;

  localparam int DC = 4;
  localparam int CW = 3;

`ifdef PUSH_DEBOUNCE_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn_raw = 2'b00;
  logic       push1;
  logic       push2;
  logic [1:0] btn_level;

  int pass_count  = 0;
  int check_count = 0;
  int fail_count  = 0;

  push_debounce #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .push1    (push1),
    .push2    (push2),
    .btn_level(btn_level)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic r, input logic [1:0] b);
    rst     = r;
    btn_raw = b;
  endtask

  task automatic check_one(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // p1/p2 are the strobe-build expectations; the level build derives its
  // push values from the expected debounced level
  task automatic check_output(input string tag, input logic p1, input logic p2,
                              input logic [1:0] lvl);
    logic ep1;
    logic ep2;
    ep1 = PULSE ? p1 : lvl[0];
    ep2 = PULSE ? p2 : (lvl[1] & ~lvl[0]);
    check_one({tag, ".push1"}, {1'b0, push1}, {1'b0, ep1});
    check_one({tag, ".push2"}, {1'b0, push2}, {1'b0, ep2});
    check_one({tag, ".level"}, btn_level, lvl);
  endtask

  initial begin
    $display("[TB] push_debounce bench, DEBOUNCE_CYCLES=%0d, pulse build=%0d", DC, PULSE);

    // Reset
    apply_stimulus(1'b1, 2'b00);
    tick();
    tick();
    check_output("reset", 1'b0, 1'b0, 2'b00);

    // Button 1 stable press, then release
    apply_stimulus(1'b0, 2'b01);
    for (int e = 0; e < 8; e++) begin
      tick();
      check_output($sformatf("t1press.e%0d", e), e == 5, 1'b0, (e >= 5) ? 2'b01 : 2'b00);
    end
    apply_stimulus(1'b0, 2'b00);
    for (int e = 0; e < 8; e++) begin
      tick();
      check_output($sformatf("t1rel.e%0d", e), 1'b0, 1'b0, (e >= 5) ? 2'b00 : 2'b01);
    end

    // Bouncing button 1, toggling every two cycles
    for (int i = 0; i < 30; i++) begin
      apply_stimulus(1'b0, {1'b0, ((i / 2) % 2) == 1});
      tick();
      check_output($sformatf("t2bounce.i%0d", i), 1'b0, 1'b0, 2'b00);
    end
    apply_stimulus(1'b0, 2'b01);
    for (int e = 0; e < 8; e++) begin
      tick();
      check_output($sformatf("t2press.e%0d", e), e == 5, 1'b0, (e >= 5) ? 2'b01 : 2'b00);
    end
    apply_stimulus(1'b0, 2'b00);
    for (int e = 0; e < 8; e++) begin
      tick();
      check_output($sformatf("t2rel.e%0d", e), 1'b0, 1'b0, (e >= 5) ? 2'b00 : 2'b01);
    end

    // Both buttons pressed together, then button 1 released, then button 2
    apply_stimulus(1'b0, 2'b11);
    for (int e = 0; e < 8; e++) begin
      tick();
      check_output($sformatf("t3both.e%0d", e), e == 5, e == 6, (e >= 5) ? 2'b11 : 2'b00);
    end
    apply_stimulus(1'b0, 2'b10);
    for (int e = 0; e < 8; e++) begin
      tick();
      check_output($sformatf("t3rel1.e%0d", e), 1'b0, 1'b0, (e >= 5) ? 2'b10 : 2'b11);
    end
    apply_stimulus(1'b0, 2'b00);
    for (int e = 0; e < 8; e++) begin
      tick();
      check_output($sformatf("t3rel2.e%0d", e), 1'b0, 1'b0, (e >= 5) ? 2'b00 : 2'b10);
    end

    // Long hold on button 1: a single strobe, then a silent release
    apply_stimulus(1'b0, 2'b01);
    for (int e = 0; e < 50; e++) begin
      tick();
      check_output($sformatf("t4hold.e%0d", e), e == 5, 1'b0, (e >= 5) ? 2'b01 : 2'b00);
    end
    apply_stimulus(1'b0, 2'b00);
    for (int e = 0; e < 8; e++) begin
      tick();
      check_output($sformatf("t4rel.e%0d", e), 1'b0, 1'b0, (e >= 5) ? 2'b00 : 2'b01);
    end

    // Reset during ARM_PRESS with button 1 held throughout
    apply_stimulus(1'b0, 2'b01);
    for (int e = 0; e < 4; e++) begin
      tick();
      check_output($sformatf("t5arm.e%0d", e), 1'b0, 1'b0, 2'b00);
    end
    apply_stimulus(1'b1, 2'b01);
    tick();
    check_output("t5rst0", 1'b0, 1'b0, 2'b00);
    tick();
    check_output("t5rst1", 1'b0, 1'b0, 2'b00);
    apply_stimulus(1'b0, 2'b01);
    for (int e = 0; e < 8; e++) begin
      tick();
      check_output($sformatf("t5post.e%0d", e), e == 5, 1'b0, (e >= 5) ? 2'b01 : 2'b00);
    end
    apply_stimulus(1'b0, 2'b00);
    for (int e = 0; e < 8; e++) begin
      tick();
      check_output($sformatf("t5rel.e%0d", e), 1'b0, 1'b0, (e >= 5) ? 2'b00 : 2'b01);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/push_debounce.md
# push_debounce

Conditions the two raw board push buttons into clean, glitch-free load strobes for the 4-bit equality comparator that follows it. It sits directly upstream of the comparator: its `push1`/`push2` outputs drive the comparator's `push1`/`push2` inputs. Each button is synchronised, debounced with a per-button stability counter and state machine, and converted to a single-cycle strobe. Both strobes are never high in the same cycle.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable synchronised samples required to accept a level change (10 ms at 100 MHz). Legal values are ≥ 2.
- `CNT_W`, default 20: counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports (clock and reset first):
- `clk`  in  1  system clock; one clock domain only.
- `rst`  in  1  synchronous, active-high reset.
- `btn_raw`  in  2  asynchronous raw buttons. Bit 0 is button 1, bit 1 is button 2; a button reads 1 when pressed.
- `push1`  out  1  strobe that tells the comparator to load operand a.
- `push2`  out  1  strobe that tells the comparator to load operand b.
- `btn_level`  out  2  debounced button levels.

## Operation
- Synchroniser: each `btn_raw` bit passes through 2 flops (`s0` then `s1`). All logic below uses `s1` only.
- Per-button FSM, with one counter per button:
  - IDLE: level is 0. If `s1`=1, clear the counter and go to ARM_PRESS.
  - ARM_PRESS: if `s1`=0, go back to IDLE. Otherwise increment the counter. When the counter equals DEBOUNCE_CYCLES-1 while `s1`=1, go to HELD, set level to 1 and raise an internal press event for one cycle.
  - HELD: level is 1. If `s1`=0, clear the counter and go to ARM_RELEASE.
  - ARM_RELEASE: if `s1`=1, go back to HELD. Otherwise increment the counter. When the counter equals DEBOUNCE_CYCLES-1 while `s1`=0, go to IDLE and set level to 0.
- Any bounce during an ARM state aborts back to the previous stable state. The counter restarts on the next entry.
- Strobe arbitration:
  - A press event on button 1 drives `push1`=1 for exactly one cycle.
  - A press event on button 2 drives `push2`=1 for exactly one cycle.
  - If both press events occur in the same cycle, `push1` fires in that cycle. The button-2 event is held in a `pend2` flag, and `push2` fires in the next cycle.
  - `pend2` holds at most one event. A new button-2 event cannot arrive while `pend2` is set, because of the debounce time.
- Counter width: the counter saturates at DEBOUNCE_CYCLES-1 and never wraps.

## Timing
- Reset values: `push1`=0, `push2`=0, `btn_level`=0. Synchroniser flops, counters and `pend2` are 0, and both FSMs are in IDLE.
- Press latency: `btn_raw` is first sampled high at edge k and stays stable. `btn_level` and the strobe (in its level form) go high after edge k+1+DEBOUNCE_CYCLES, which is 1+DEBOUNCE_CYCLES edges later.
- A strobe lasts exactly one cycle. There is no repeat strobe while a button stays held.
- Release latency: the same 1+DEBOUNCE_CYCLES edges until `btn_level` falls. A release produces no strobe.
- Reset asserted mid-operation: everything returns to reset values on the next edge.
  - A strobe in flight is dropped.
  - A button held across reset is debounced afresh after `rst` falls and produces one new strobe.
- Minimum spacing between two strobes from the same button: 2×DEBOUNCE_CYCLES cycles.

## Configuration
- `PUSH_DEBOUNCE_PULSE_EN`
  - Defined: `push1`/`push2` are one-cycle strobes, as described above.
  - Undefined: `push1`/`push2` equal `btn_level[0]`/`btn_level[1]` (level mode). Arbitration still applies: while `btn_level[0]`=1, `push2` is forced to 0. `pend2` is not built.
  - `btn_level` behaves the same in both builds.

## Test plan
Bench uses DEBOUNCE_CYCLES=4 and `PUSH_DEBOUNCE_PULSE_EN` defined unless stated.
- Reset, then `btn_raw`=01 held stable from edge 0 → `push1`=1 for one cycle only after edge 5, `btn_level`=01 from then on, and `push2` stays 0.
- `btn_raw[0]` toggling every 2 cycles for 30 cycles → no strobe and `btn_level`=00 throughout. A following stable press → exactly one strobe, 5 edges after the press is first sampled.
- `btn_raw`=11 applied in one cycle → `push1` pulses after edge 5 and `push2` pulses after edge 6. The two are never high together.
- Button 1 held stable for 50 cycles → exactly one `push1` pulse. After release, `btn_level[0]` falls 5 edges after the release is first sampled, with no strobe.
- `rst` asserted two cycles into ARM_PRESS while the button is held, then released → all outputs 0 during reset, then one `push1` pulse 5 edges after the first post-reset sample.
- `PUSH_DEBOUNCE_PULSE_EN` undefined, `btn_raw`=11 stable → `push1`=1 continuously and `push2`=0. Releasing button 1 → `push2`=1 once `btn_level[0]` falls.
